multicycle_controller: RTL

//  Control FSM that sequences the shared-memory multicycle ARM datapath (single ALU, single memory, vector RF).

---
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle ARM datapath.
// Decodes the held IR fields, sequences each instruction through its states,
// owns the NZCV flags register and gates every architectural write with the
// condition check. The condition is latched in DECODE, so a flag update made
// by an instruction only becomes visible to the following instruction.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic        VecWrite,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXER   = 4'd6,
        EXEI   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        VEXEC  = 4'd10,
        VWB    = 4'd11
    } state_t;

    state_t     state_reg;
    logic [3:0] flags_reg;   // {N,Z,C,V}
    logic       cond_reg;    // condition result for the instruction in flight

    // IR field split
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       is_add, is_sub, is_cmp;
    logic [1:0] flag_w;
    logic [2:0] dec_alu;
    logic       cond_ex;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];
    assign cmd       = funct[4:1];
    assign is_add    = (cmd == 4'b0100);
    assign is_sub    = (cmd == 4'b0010);
    assign is_cmp    = (cmd == 4'b1010);

    // CMP always behaves as if S were set
    assign flag_w[1] = funct[0] | is_cmp;
    assign flag_w[0] = (funct[0] | is_cmp) & (is_add | is_sub | is_cmp);

    // Data-processing command to ALU operation
    always_comb begin
        dec_alu = 3'b000;
        case (cmd)
            4'b0100: dec_alu = 3'b000;
            4'b0010: dec_alu = 3'b001;
            4'b0000: dec_alu = 3'b010;
            4'b1100: dec_alu = 3'b011;
            4'b1010: dec_alu = 3'b001;
            default: dec_alu = 3'b000;
        endcase
    end

    // ARM condition check against the registered flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_reg[2];
            4'b0001: cond_ex = ~flags_reg[2];
            4'b0010: cond_ex = flags_reg[1];
            4'b0011: cond_ex = ~flags_reg[1];
            4'b0100: cond_ex = flags_reg[3];
            4'b0101: cond_ex = ~flags_reg[3];
            4'b0110: cond_ex = flags_reg[0];
            4'b0111: cond_ex = ~flags_reg[0];
            4'b1000: cond_ex = flags_reg[1] & ~flags_reg[2];
            4'b1001: cond_ex = ~flags_reg[1] | flags_reg[2];
            4'b1010: cond_ex = (flags_reg[3] == flags_reg[0]);
            4'b1011: cond_ex = (flags_reg[3] != flags_reg[0]);
            4'b1100: cond_ex = ~flags_reg[2] & (flags_reg[3] == flags_reg[0]);
            4'b1101: cond_ex = flags_reg[2] | (flags_reg[3] != flags_reg[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // State sequencing, condition latch and flag update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            flags_reg <= 4'b0000;
            cond_reg  <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: state_reg <= DECODE;
                DECODE: begin
                    cond_reg <= cond_ex;
                    case (op)
                        2'b00:   state_reg <= funct[5] ? EXEI : EXER;
                        2'b01:   state_reg <= MEMADR;
                        2'b10:   state_reg <= BRANCH;
                        default: state_reg <= VEXEC;
                    endcase
                end
                MEMADR: state_reg <= funct[0] ? MEMRD : MEMWR;
                MEMRD:  state_reg <= MEMWB;
                EXER, EXEI: begin
                    if (cond_reg) begin
                        if (flag_w[1]) flags_reg[3:2] <= ALUFlags[3:2];
                        if (flag_w[0]) flags_reg[1:0] <= ALUFlags[1:0];
                    end
                    state_reg <= is_cmp ? FETCH : ALUWB;
                end
                VEXEC:  state_reg <= VWB;
                default: state_reg <= FETCH;
            endcase
        end
    end

    // Moore control decode; write enables also need the condition and no reset
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        RegWrite   = 1'b0;
        VecWrite   = 1'b0;
        case (state_reg)
            FETCH: begin
                IRWrite   = ~reset;
                PCWrite   = ~reset;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = funct[3] ? 3'b000 : 3'b001;
            end
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_reg & ~reset;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_reg & ~reset;
            end
            EXER:   ALUControl = dec_alu;
            EXEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dec_alu;
            end
            ALUWB: begin
                RegWrite = cond_reg & (rd != 4'd15) & ~reset;
                PCWrite  = cond_reg & (rd == 4'd15) & ~reset;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_reg & ~reset;
            end
            VEXEC:  ALUControl = dec_alu;
            VWB:    VecWrite = cond_reg & ~reset;
            default: ;
        endcase
    end

    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign State  = state_reg;

endmodule
